esc_pwm_gen: RTL and testbench

//  Downstream of the flight controller: turns the four 11-bit unsigned motor speeds into

---
 rtl/esc_pwm_gen.sv | 138 +++++++++++++
 tb/tb_esc_pwm_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/esc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : esc_pwm_gen
// Purpose  : Four-channel hobby-ESC servo pulse generator with arming sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module esc_pwm_gen #(
  parameter int PERIOD     = 1_000_000,
  parameter int MIN_CLKS   = 50_000,
  parameter int MULT       = 24,
  parameter int ARM_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frame_strt,
  output logic        armed
);

  localparam int CW = $clog2(PERIOD);
  localparam int AW = $clog2(ARM_FRAMES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMING = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [1:0] LOAD_ZERO = 2'd0;
  localparam logic [1:0] LOAD_MIN  = 2'd1;
  localparam logic [1:0] LOAD_SPD  = 2'd2;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        arm_cnt_q, arm_cnt_d;
  logic                 armed_q, armed_d;
  logic [3:0]           pwm_q, pwm_d;
  logic [3:0][CW-1:0]   width_q, width_d;
  logic [3:0][10:0]     spd;
  logic                 boundary;
  logic [1:0]           load;

  assign spd      = {rght_spd, lft_spd, bck_spd, frnt_spd};
  assign boundary = (cnt_q == CW'(PERIOD - 1));

  // Sequencer: every decision, and the choice of width source, is made only at the frame boundary.
  always_comb begin
    cnt_d     = boundary ? '0 : cnt_q + CW'(1);
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    load      = LOAD_ZERO;
    if (boundary) begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d   = ST_ARMING;
            arm_cnt_d = AW'(1);
            load      = LOAD_MIN;
          end
        end
        ST_ARMING: begin
          if (!en) begin
            state_d   = ST_IDLE;
            arm_cnt_d = '0;
          end else if (arm_cnt_q == AW'(ARM_FRAMES)) begin
            state_d = ST_RUN;
            load    = LOAD_SPD;
          end else begin
            arm_cnt_d = arm_cnt_q + AW'(1);
            load      = LOAD_MIN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else begin
            load = LOAD_SPD;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          arm_cnt_d = '0;
        end
      endcase
    end
    armed_d = (state_d == ST_RUN);
  end

  // pwm is registered from next-cycle count and width so the flop tracks cnt_q exactly.
  always_comb begin
    width_d = width_q;
    pwm_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (boundary) begin
        case (load)
          LOAD_MIN: width_d[i] = CW'(MIN_CLKS);
          LOAD_SPD: width_d[i] = CW'(MIN_CLKS) + CW'(spd[i]) * CW'(MULT);
          default:  width_d[i] = '0;
        endcase
      end
      pwm_d[i] = (cnt_d < width_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      pwm_q     <= '0;
      width_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      pwm_q     <= pwm_d;
      width_q   <= width_d;
    end
  end

  assign frnt_pwm   = pwm_q[0];
  assign bck_pwm    = pwm_q[1];
  assign lft_pwm    = pwm_q[2];
  assign rght_pwm   = pwm_q[3];
  assign armed      = armed_q;
  // Gated by rst so the strobe is silent during reset yet present in the very first frame after it.
  assign frame_strt = ~rst & (cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_esc_pwm_gen
// Purpose  : Scoreboard bench for esc_pwm_gen; per-frame pulse widths and armed state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esc_pwm_gen;

  localparam int P = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [10:0] frnt_spd = 11'h400;
  logic [10:0] bck_spd  = 11'h400;
  logic [10:0] lft_spd  = 11'h400;
  logic [10:0] rght_spd = 11'h400;
  logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frame_strt, armed;

  esc_pwm_gen #(
    .PERIOD(P), .MIN_CLKS(500), .MULT(2), .ARM_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
    .frame_strt(frame_strt), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic             armed;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   end_chk  = 1'b0;
  bit   end_done = 1'b0;

  task automatic push(input int a, input int b, input int c, input int d, input bit arm);
    exp_t e;
    e.w     = {16'(d), 16'(c), 16'(b), 16'(a)};
    e.armed = arm;
    sb_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- monitor
  int  hi[4];
  bit  fell[4];
  bit  glitch[4];
  int  cyc      = 0;
  int  fidx     = 0;
  bit  in_frame = 1'b0;
  bit  arm_s    = 1'b0;
  bit  prev_rst = 1'b1;
  bit  prev_bck = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic close_frame();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk($sformatf("f%0d_unexpected_frame", fidx), 1, 0);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("f%0d_width_ch%0d", fidx, i), hi[i], int'(e.w[i]));
        chk($sformatf("f%0d_contiguous_ch%0d", fidx, i), int'(glitch[i]), 0);
      end
      chk($sformatf("f%0d_armed", fidx), int'(arm_s), int'(e.armed));
      chk($sformatf("f%0d_period", fidx), cyc, P);
    end
    fidx++;
  endtask

  always @(negedge clk) begin
    logic [3:0] pwm;
    pwm = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};
    if (rst) begin
      if (!prev_rst) begin
        chk("rst_pulse_was_active", int'(prev_bck), 1);
        chk("rst_pwm_low", int'(pwm), 0);
        chk("rst_armed_low", int'(armed), 0);
        chk("rst_frame_strt_low", int'(frame_strt), 0);
      end
      in_frame = 1'b0;
    end else begin
      if (prev_rst) chk("frame_strt_after_rst", int'(frame_strt), 1);
      if (frame_strt) begin
        if (in_frame) close_frame();
        in_frame = 1'b1;
        cyc      = 0;
        arm_s    = armed;
        for (int i = 0; i < 4; i++) begin
          hi[i] = 0; fell[i] = 1'b0; glitch[i] = 1'b0;
        end
      end
      if (in_frame) begin
        for (int i = 0; i < 4; i++) begin
          if (pwm[i]) begin
            if (fell[i]) glitch[i] = 1'b1;
            hi[i]++;
          end else begin
            fell[i] = 1'b1;
          end
        end
        cyc++;
      end
      prev_bck = bck_pwm;
    end
    if (end_chk && !end_done) begin
      chk("scoreboard_drained", sb_q.size(), 0);
      end_done = 1'b1;
    end
    prev_rst = rst;
  end

  // --------------------------------------------------------------- stimulus
  // Returns at the negedge of the cnt==k cycle of the next frame.
  task automatic frame_at(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 2 * P) begin
        $display("FAIL frame_wait: no frame_strt within %0d clks", 2 * P);
        $fatal(1, "frame wait expired");
      end
    end while (!frame_strt);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    push(0, 0, 0, 0, 1'b0);
    push(500, 500, 500, 500, 1'b0);
    push(500, 500, 500, 500, 1'b0);
    push(2548, 2548, 2548, 2548, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    frame_at(0);                       // F0
    frame_at(0);                       // F1
    frame_at(0);                       // F2
    frame_at(100);                     // F3
    frnt_spd = 11'h100;
    push(1012, 2548, 2548, 2548, 1'b1);

    frame_at(200);                     // F4: mid-frame change must not matter
    frnt_spd = 11'h7FF;
    repeat (2800) @(negedge clk);
    bck_spd  = 11'h7FF;
    lft_spd  = 11'h001;
    rght_spd = 11'h3FF;
    push(4594, 4594, 502, 2546, 1'b1);

    frame_at(4700);                    // F5
    frnt_spd = 11'h000;
    push(500, 4594, 502, 2546, 1'b1);

    frame_at(100);                     // F6: disable mid-pulse
    en = 1'b0;
    push(0, 0, 0, 0, 1'b0);

    frame_at(50);                      // F7: idle, re-enable
    en = 1'b1;
    push(500, 500, 500, 500, 1'b0);

    frame_at(700);                     // F8: arming, disable
    en = 1'b0;
    push(0, 0, 0, 0, 1'b0);

    frame_at(50);                      // F9: idle, re-enable
    en = 1'b1;
    push(500, 500, 500, 500, 1'b0);
    push(500, 500, 500, 500, 1'b0);
    push(500, 4594, 502, 2546, 1'b1);

    frame_at(0);                       // F10
    frame_at(0);                       // F11
    frame_at(0);                       // F12
    frame_at(2999);                    // F13, cnt 2999
    @(posedge clk);
    #1 rst = 1'b1;                     // cnt==3000 cycle, back pulse still high
    push(0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    frame_at(0);                       // F0 after reset
    frame_at(2);                       // F1 starts, F0 closed
    end_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
